mem_port_sequencer: RTL and testbench

- Control sequencer for the memory data register path: drives MAR/MDR load enables, MDR source select and memory read/write strobes.
- Arbitrates the single memory port between the instruction-fetch requester and the load/store requester.
- Sits between the control unit and the MAR/MDR/memory datapath.
- Handles variable-latency memory through a ready handshake with a timeout.

---
 rtl/mem_port_sequencer.sv | 155 +++++++++++++++
 tb/tb_mem_port_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_sequencer.sv
// mem_port_sequencer
// Sequences the MAR/MDR/memory datapath for one memory access at a time. It
// also arbitrates the single memory port between the instruction-fetch
// requester and the load/store requester.
//
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous reset, active-low
//   if_req     fetch requester wants a memory read
//   ls_req     load/store requester wants an access
//   ls_write   1=store, 0=load; sampled with ls_req at grant
//   mem_ready  memory finished current access
//   if_grant   fetch owns the port (ADDR..DONE)
//   ls_grant   load/store owns the port (ADDR..DONE)
//   busy       state != IDLE
//   done       one-cycle completion pulse
//   err        one-cycle pulse with done on timeout
//   MAR_in     load MAR from bus
//   MDR_in     MDR load enable
//   MDR_read   MDR source: 1=memory data, 0=bus
//   mem_read   memory read strobe
//   mem_write  memory write strobe
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | port free; requests sampled and arbitrated here only
// ADDR      | MAR loads the address from the bus
// LATCH     | store only: MDR latches write data from the bus
// MEM_WAIT  | strobe held; wait for mem_ready or TIMEOUT cycles
// CAPTURE   | read only: MDR latches memory data
// DONE      | done pulse (err with it on timeout); grants drop after this

module mem_port_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic clk,
  input  logic clr,
  input  logic if_req,
  input  logic ls_req,
  input  logic ls_write,
  input  logic mem_ready,
  output logic if_grant,
  output logic ls_grant,
  output logic busy,
  output logic done,
  output logic err,
  output logic MAR_in,
  output logic MDR_in,
  output logic MDR_read,
  output logic mem_read,
  output logic mem_write
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    LATCH    = 3'd2,
    MEM_WAIT = 3'd3,
    CAPTURE  = 3'd4,
    DONE     = 3'd5
  } state_t;

  // Counter value on the edge that completes the TIMEOUT-th wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic              err_flag, err_flag_nx;
  logic              last_ls, last_ls_nx;     // 1: last grant went to load/store
  logic              op_write, op_write_nx;
  logic              owner_ls, owner_ls_nx;   // 1: current operation belongs to load/store

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      err_flag <= 1'b0;
      last_ls  <= 1'b1;   // fetch wins the first tie
      op_write <= 1'b0;
      owner_ls <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      err_flag <= err_flag_nx;
      last_ls  <= last_ls_nx;
      op_write <= op_write_nx;
      owner_ls <= owner_ls_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    err_flag_nx = err_flag;
    last_ls_nx  = last_ls;
    op_write_nx = op_write;
    owner_ls_nx = owner_ls;
    case (state)
      IDLE: begin
        // Fetch takes the port when alone, or on a tie when LS had it last.
        if (if_req && (!ls_req || last_ls)) begin
          owner_ls_nx = 1'b0;
          last_ls_nx  = 1'b0;
          op_write_nx = 1'b0;
          state_nx    = ADDR;
        end else if (ls_req) begin
          owner_ls_nx = 1'b1;
          last_ls_nx  = 1'b1;
          op_write_nx = ls_write;
          state_nx    = ADDR;
        end
      end
      ADDR:    state_nx = op_write ? LATCH : MEM_WAIT;
      LATCH:   state_nx = MEM_WAIT;
      MEM_WAIT: begin
        // Ready is checked first so a same-edge ready beats the timeout.
        if (mem_ready) begin
          cnt_nx   = '0;
          state_nx = op_write ? DONE : CAPTURE;
        end else if (cnt == CNT_LAST) begin
          cnt_nx      = '0;
          err_flag_nx = 1'b1;
          state_nx    = DONE;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      CAPTURE: state_nx = DONE;
      DONE: begin
        err_flag_nx = 1'b0;
        state_nx    = IDLE;
      end
      default: begin
        cnt_nx      = '0;
        err_flag_nx = 1'b0;
        state_nx    = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    if_grant  = busy && !owner_ls;
    ls_grant  = busy && owner_ls;
    done      = (state == DONE);
    err       = (state == DONE) && err_flag;
    MAR_in    = (state == ADDR);
    MDR_in    = (state == LATCH) || (state == CAPTURE);
    MDR_read  = (state == CAPTURE);
    mem_read  = (state == MEM_WAIT) && !op_write;
    mem_write = (state == MEM_WAIT) && op_write;
  end

endmodule

// File: tb/tb_mem_port_sequencer.sv
// tb_mem_port_sequencer
// Directed bench for mem_port_sequencer. Inputs change and outputs are
// sampled on the falling edge. Every output is packed into one vector and
// compared against hand-written per-cycle patterns.
module tb_mem_port_sequencer;

  logic clk = 1'b0;
  logic clr, if_req, ls_req, ls_write, mem_ready;
  logic if_grant, ls_grant, busy, done, err;
  logic MAR_in, MDR_in, MDR_read, mem_read, mem_write;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_sequencer #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .if_req    (if_req),
    .ls_req    (ls_req),
    .ls_write  (ls_write),
    .mem_ready (mem_ready),
    .if_grant  (if_grant),
    .ls_grant  (ls_grant),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .MAR_in    (MAR_in),
    .MDR_in    (MDR_in),
    .MDR_read  (MDR_read),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );

  // {if_grant, ls_grant, busy, done, err, MAR_in, MDR_in, MDR_read, mem_read, mem_write}
  logic [9:0] outs;
  assign outs = {if_grant, ls_grant, busy, done, err,
                 MAR_in, MDR_in, MDR_read, mem_read, mem_write};

  // Grant field
  localparam logic [1:0] G_F = 2'b10;
  localparam logic [1:0] G_L = 2'b01;
  // Phase field: busy done err MAR_in MDR_in MDR_read mem_read mem_write
  localparam logic [7:0] P_ADDR     = 8'b1001_0000;
  localparam logic [7:0] P_LATCH    = 8'b1000_1000;
  localparam logic [7:0] P_WAIT_RD  = 8'b1000_0010;
  localparam logic [7:0] P_WAIT_WR  = 8'b1000_0001;
  localparam logic [7:0] P_CAPT     = 8'b1000_1100;
  localparam logic [7:0] P_DONE     = 8'b1100_0000;
  localparam logic [7:0] P_DONE_ERR = 8'b1110_0000;
  localparam logic [9:0] V_IDLE     = 10'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_check(input string tag, input logic [9:0] exp);
    tick();
    check_eq(tag, {22'b0, outs}, {22'b0, exp});
  endtask

  initial begin
    clr = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_write = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("reset_outputs", {22'b0, outs}, 32'd0);
    clr = 1'b1;
    step_check("idle_after_release", V_IDLE);

    // Single fetch, zero-wait memory; mem_ready high early must not shortcut.
    if_req = 1'b1; mem_ready = 1'b1;
    step_check("fetch_addr", {G_F, P_ADDR});
    if_req = 1'b0;
    step_check("fetch_wait", {G_F, P_WAIT_RD});
    step_check("fetch_capture", {G_F, P_CAPT});
    step_check("fetch_done", {G_F, P_DONE});
    mem_ready = 1'b0;
    step_check("fetch_idle", V_IDLE);

    // Store with mem_ready arriving in the third wait cycle.
    ls_req = 1'b1; ls_write = 1'b1;
    step_check("store_addr", {G_L, P_ADDR});
    ls_req = 1'b0; ls_write = 1'b0;
    step_check("store_latch", {G_L, P_LATCH});
    step_check("store_wait1", {G_L, P_WAIT_WR});
    step_check("store_wait2", {G_L, P_WAIT_WR});
    step_check("store_wait3", {G_L, P_WAIT_WR});
    mem_ready = 1'b1;
    step_check("store_done", {G_L, P_DONE});
    mem_ready = 1'b0;
    step_check("store_idle", V_IDLE);

    // Reset in the middle of MEM_WAIT drops everything at once.
    if_req = 1'b1;
    step_check("rst_op_addr", {G_F, P_ADDR});
    if_req = 1'b0;
    step_check("rst_op_wait", {G_F, P_WAIT_RD});
    clr = 1'b0;
    #1;
    check_eq("rst_async_outputs", {22'b0, outs}, 32'd0);
    step_check("rst_held", V_IDLE);
    clr = 1'b1;
    step_check("rst_released_idle", V_IDLE);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);

    // Both requesters held after a fresh reset: fetch, LS, fetch, LS.
    clr = 1'b0;
    tick();
    clr = 1'b1;
    if_req = 1'b1; ls_req = 1'b1; ls_write = 1'b0; mem_ready = 1'b1;
    for (int op = 0; op < 4; op++) begin
      logic [1:0] g;
      g = (op % 2 == 0) ? G_F : G_L;
      step_check($sformatf("rr%0d_addr", op), {g, P_ADDR});
      step_check($sformatf("rr%0d_wait", op), {g, P_WAIT_RD});
      step_check($sformatf("rr%0d_capt", op), {g, P_CAPT});
      step_check($sformatf("rr%0d_done", op), {g, P_DONE});
      if (op == 3) begin
        if_req = 1'b0; ls_req = 1'b0;
      end
      step_check($sformatf("rr%0d_idle", op), V_IDLE);
    end
    mem_ready = 1'b0;

    // Load that never sees mem_ready: 15 wait cycles, then done+err, no MDR load.
    ls_req = 1'b1; ls_write = 1'b0;
    step_check("to_addr", {G_L, P_ADDR});
    ls_req = 1'b0;
    for (int i = 1; i <= 15; i++)
      step_check($sformatf("to_wait%0d", i), {G_L, P_WAIT_RD});
    step_check("to_done_err", {G_L, P_DONE_ERR});
    step_check("to_idle", V_IDLE);

    // mem_ready on the same edge as the timeout: no error, capture runs.
    if_req = 1'b1;
    step_check("tie_addr", {G_F, P_ADDR});
    if_req = 1'b0;
    for (int i = 1; i <= 15; i++)
      step_check($sformatf("tie_wait%0d", i), {G_F, P_WAIT_RD});
    mem_ready = 1'b1;
    step_check("tie_capture", {G_F, P_CAPT});
    mem_ready = 1'b0;
    step_check("tie_done_noerr", {G_F, P_DONE});
    step_check("tie_idle", V_IDLE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
